// File: rtl/converter_seq.sv
// Sequencer that feeds an Excess-3 digit LSB-first to an external serial
// converter and collects the BCD result. Optional range check: CV_RANGE_CHK_EN.
module converter_seq (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       In_Valid,
  input  logic [3:0] In_Data,
  output logic       In_Ready,
  output logic       Out_Valid,
  output logic [3:0] Out_Data,
  output logic       Out_Err,
  input  logic       Out_Ready,
  output logic       Conv_X,
  output logic       Conv_Rst,
  input  logic       Conv_Z,
  output logic [7:0] Done_Cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLR   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] bit_q, bit_d;
  logic [3:0] digit_q, digit_d;
  logic [3:0] res_q, res_d;
  logic [7:0] cnt_q, cnt_d;

`ifdef CV_RANGE_CHK_EN
  logic err_q, err_d;
  logic in_range;
  assign in_range = (In_Data >= 4'd3) && (In_Data <= 4'd12);
`endif

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    digit_d = digit_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
`ifdef CV_RANGE_CHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: if (In_Valid) begin
        digit_d = In_Data;
        state_d = S_CLR;
`ifdef CV_RANGE_CHK_EN
        err_d   = 1'b0;
        // out-of-range digits bypass the converter entirely
        if (!in_range) begin
          err_d   = 1'b1;
          res_d   = 4'hF;
          state_d = S_DONE;
        end
`endif
      end
      S_CLR: begin
        bit_d   = 2'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        res_d[bit_q] = Conv_Z;
        bit_d        = bit_q + 2'd1;
        if (bit_q == 2'd3) state_d = S_DONE;
      end
      default: if (Out_Ready) begin
        state_d = S_IDLE;
        cnt_d   = cnt_q + 8'd1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      bit_q   <= 2'd0;
      digit_q <= 4'd0;
      res_q   <= 4'd0;
      cnt_q   <= 8'd0;
`ifdef CV_RANGE_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      digit_q <= digit_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
`ifdef CV_RANGE_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign In_Ready  = (state_q == S_IDLE);
  assign Out_Valid = (state_q == S_DONE);
  assign Out_Data  = (state_q == S_DONE) ? res_q : 4'd0;
  assign Conv_Rst  = (state_q == S_SHIFT);
  assign Conv_X    = (state_q == S_SHIFT) ? digit_q[bit_q] : 1'b0;
  assign Done_Cnt  = cnt_q;
`ifdef CV_RANGE_CHK_EN
  assign Out_Err   = (state_q == S_DONE) && err_q;
`else
  assign Out_Err   = 1'b0;
`endif

endmodule

// File: doc/converter_seq.md
CONVERTER_SEQ -- requirements
Module: converter_seq

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Clk  in  1  system clock; all state updates on the rising edge.
REQ-003 Rst  in  1  synchronous active-high reset.
REQ-004 In_Valid  in  1  upstream Excess-3 digit valid.
REQ-005 In_Data  in  4  Excess-3 digit, bit 0 = LSB.
REQ-006 In_Ready  out  1  block can accept a digit.
REQ-007 Out_Valid  out  1  converted BCD digit available.
REQ-008 Out_Data  out  4  BCD result, bit 0 = LSB.
REQ-009 Out_Err  out  1  digit rejected as out of range; tied 0 when the range check is compiled out.
REQ-010 Out_Ready  in  1  downstream accepts Out_Data.
REQ-011 Conv_X  out  1  serial bit to the converter, LSB first.
REQ-012 Conv_Rst  out  1  converter reset, active-low (0 = clear converter).
REQ-013 Conv_Z  in  1  converter serial output for the bit currently on Conv_X, combinational within the same cycle.
REQ-014 Done_Cnt  out  8  count of completed output handshakes.

Function
REQ-015 States SHALL be IDLE, CLR, SHIFT and DONE, with a 2-bit bit counter Bit_Idx.
REQ-016 In IDLE:
- In_Ready SHALL be 1 and Conv_Rst SHALL be 0.
- When In_Valid is 1 at a rising edge, In_Data SHALL be latched and the state SHALL go to CLR.
REQ-017 In_Ready SHALL be 0 in every state except IDLE.
REQ-018 CLR SHALL last exactly one cycle:
- Conv_Rst = 0 and Conv_X = 0.
- Next state SHIFT with Bit_Idx = 0.
REQ-019 In SHIFT:
- Conv_Rst = 1 and Conv_X = latched_digit[Bit_Idx].
- At each rising edge, Conv_Z SHALL be captured into result[Bit_Idx] and Bit_Idx SHALL increment.
REQ-020 The edge that captures Bit_Idx = 3 SHALL move the state to DONE; SHIFT lasts exactly 4 cycles.
REQ-021 In DONE:
- Out_Valid = 1, Out_Data = result and Conv_Rst = 0.
- Out_Data SHALL be held stable until Out_Ready = 1 at a rising edge.
- That edge SHALL move the state to IDLE and increment Done_Cnt.
REQ-022 Latency SHALL be fixed: accept at edge k gives Out_Valid = 1 after edge k+5.
REQ-023 The next digit SHALL be accepted no earlier than the edge after the output handshake, so the minimum period is 7 cycles per digit.
REQ-024 Done_Cnt SHALL wrap from 255 to 0 without any flag.
REQ-025 Out_Ready asserted outside DONE SHALL be ignored; In_Valid asserted outside IDLE SHALL be ignored, and In_Data is not sampled.

Reset
REQ-026 While Rst = 1 at a rising edge, the block SHALL enter IDLE, clear Bit_Idx, the latched digit and result to 0, and clear Done_Cnt to 0.
REQ-027 Output values under reset:
- In_Ready = 1, Out_Valid = 0, Out_Data = 0, Out_Err = 0.
- Conv_X = 0, Conv_Rst = 0.
REQ-028 Reset asserted in any state, including mid-SHIFT, SHALL abandon the digit with no output produced.

Configuration
REQ-029 The macro CV_RANGE_CHK_EN SHALL compile the range check in or out.
REQ-030 With CV_RANGE_CHK_EN defined, an accepted digit outside 3..12 SHALL:
- skip CLR and SHIFT and go to DONE on the next edge;
- present Out_Data = 4'hF and Out_Err = 1.
Out_Err SHALL be 0 for in-range digits.
REQ-031 Without CV_RANGE_CHK_EN, every digit SHALL be converted through CLR and SHIFT, and Out_Err SHALL be a constant 0.

Verification
REQ-032 Rst pulse, then In_Data = 4'b0011 with In_Valid = 1 and Out_Ready = 1 -> Out_Valid after 5 edges, Out_Data = 4'b0000, Done_Cnt = 1.
REQ-033 Sweep In_Data 3..12 back-to-back -> Out_Data 0..9 in order; Conv_Rst = 0 exactly one cycle before each 4-cycle SHIFT window; Conv_X carries LSB first.
REQ-034 In_Data = 4'b1100 with Out_Ready held 0 for 10 cycles -> Out_Data = 4'b1001 held stable, In_Ready = 0 throughout, Done_Cnt unchanged until Out_Ready = 1.
REQ-035 Rst = 1 during the third SHIFT cycle -> the next cycle shows IDLE outputs, no Out_Valid, Done_Cnt = 0; the following digit 4'b0111 converts to 4'b0100.
REQ-036 With CV_RANGE_CHK_EN defined, In_Data = 4'b0000 -> Out_Valid one edge after accept, Out_Data = 4'hF, Out_Err = 1, no Conv_Rst = 1 cycle; without the macro, the same stimulus runs the full 5-cycle sequence with Out_Err = 0.
REQ-037 Perform 256 handshakes -> Done_Cnt returns to 0.
